// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command frame controller: state encodings,
// default header byte, frame length and the frame checksum helper.
package uart_cmd_ctrl_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DHI  = 3'd2;
  localparam logic [2:0] S_DLO  = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hAA;
  localparam int         FRAME_LEN    = 5;

  // The CSUM byte is the XOR of the three payload bytes.
  function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                            input logic [7:0] dhi,
                                            input logic [7:0] dlo);
    return addr ^ dhi ^ dlo;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_tmo.sv
// Inter-byte timeout counter. Counts ena ticks while run is high and clr is low;
// expire is a combinational, ena-qualified pulse on the last allowed tick.
module uart_cmd_tmo #(
  parameter int TMO_TICKS = 320,
  parameter int TMO_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_TICKS - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  assign expire = run & ena & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run) begin
      cnt_d = '0;
    end else if (ena) begin
      cnt_d = expire ? '0 : cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command frame controller: assembles HDR/ADDR/DHI/DLO/CSUM frames into
// register write strobes. Optional aborted-frame counter under UART_CMD_ERRCNT_EN.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEF,
  parameter int         TMO_TICKS = 320,
  parameter int         TMO_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        rx_val,
  input  logic [7:0]  rx_data,
  input  logic        rx_no_stop,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        frm_err
`ifdef UART_CMD_ERRCNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  logic [2:0]  state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  dhi_q, dhi_d;
  logic [7:0]  dlo_q, dlo_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        frm_err_q, frm_err_d;
  logic        no_stop_q;
  logic        err_ev;
  logic        expire;

  // A held stop-bit error level counts as one event.
  assign err_ev = rx_no_stop & ~no_stop_q;

  uart_cmd_tmo #(
    .TMO_TICKS (TMO_TICKS),
    .TMO_W     (TMO_W)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .clr    (rx_val),
    .run    (state_q != S_IDLE),
    .expire (expire)
  );

  // Priority inside a frame: err_ev, then rx_val, then timeout.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dhi_d     = dhi_q;
    dlo_d     = dlo_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    frm_err_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (rx_val && rx_data == HDR_BYTE) state_d = S_ADDR;
    end else if (err_ev) begin
      frm_err_d = 1'b1;
      state_d   = S_IDLE;
    end else if (rx_val) begin
      case (state_q)
        S_ADDR: begin addr_d = rx_data; state_d = S_DHI;  end
        S_DHI:  begin dhi_d  = rx_data; state_d = S_DLO;  end
        S_DLO:  begin dlo_d  = rx_data; state_d = S_CSUM; end
        default: begin
          if (rx_data == frame_csum(addr_q, dhi_q, dlo_q)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {dhi_q, dlo_q};
          end else begin
            frm_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      endcase
    end else if (expire) begin
      frm_err_d = 1'b1;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      dhi_q     <= '0;
      dlo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      frm_err_q <= 1'b0;
      no_stop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dhi_q     <= dhi_d;
      dlo_q     <= dlo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      frm_err_q <= frm_err_d;
      no_stop_q <= rx_no_stop;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign frm_err = frm_err_q;
  assign busy    = (state_q != S_IDLE);

`ifdef UART_CMD_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Advances together with the frm_err pulse it counts; sticks at 8'hFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (frm_err_d && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl; define UART_CMD_ERRCNT_EN to also cover err_cnt.
module tb_uart_cmd_ctrl;
  import uart_cmd_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        rx_val = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_no_stop = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        frm_err;
`ifdef UART_CMD_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  logic [1:0]  ena_ph = 2'd0;
  int          n_chk = 0;
  int          n_err = 0;

  uart_cmd_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .rx_val     (rx_val),
    .rx_data    (rx_data),
    .rx_no_stop (rx_no_stop),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frm_err    (frm_err)
`ifdef UART_CMD_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers: inputs change 1 time unit after the rising edge, outputs are sampled there too
  task automatic step();
    @(posedge clk);
    #1;
    ena_ph = ena_ph + 2'd1;
    ena    = (ena_ph == 2'd3);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_val  = 1'b1;
    step();
    rx_val  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] c);
    logic [7:0] fb [FRAME_LEN];
    fb = '{8'hAA, a, h, l, c};
    for (int i = 0; i < FRAME_LEN; i++) send_byte(fb[i]);
  endtask

  // steps until n ena ticks have been consumed inside a frame; returns early frm_err pulses
  task automatic wait_ticks(input int n, output int early);
    int ticks;
    ticks = 0;
    early = 0;
    while (ticks < n) begin
      if (ena) ticks++;
      step();
      if (frm_err && ticks < n) early++;
    end
  endtask

  int pulses;
  int guard;

  initial begin
    repeat (3) step();
    check("rst_wr_en",   wr_en,   0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy",    busy,    0);
    check("rst_frm_err", frm_err, 0);
`ifdef UART_CMD_ERRCNT_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    rst = 1'b0;
    step();

    // 1: good frame
    send_byte(8'hAA);
    check("t1_busy_hdr", busy, 1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    check("t1_no_err_pre", frm_err, 0);
    send_byte(8'h70);
    check("t1_wr_en",   wr_en,   1);
    check("t1_wr_addr", wr_addr, 32'h12);
    check("t1_wr_data", wr_data, 32'h3456);
    check("t1_frm_err", frm_err, 0);
    check("t1_busy",    busy,    0);

    // 2: header back-to-back, then bad checksum
    send_byte(8'hAA);
    check("t2_b2b_wr_en_drop", wr_en, 0);
    check("t2_b2b_busy",       busy,  1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h71);
    check("t2_frm_err", frm_err, 1);
    check("t2_wr_en",   wr_en,   0);
    check("t2_wr_addr", wr_addr, 32'h12);
    check("t2_wr_data", wr_data, 32'h3456);
    check("t2_busy",    busy,    0);
    step();
    check("t2_frm_err_pulse", frm_err, 0);

    // 3: stop-bit error held for 40 clk
    send_byte(8'hAA); send_byte(8'h01);
    rx_no_stop = 1'b1;
    step();
    check("t3_frm_err_lat", frm_err, 1);
    pulses = frm_err ? 1 : 0;
    repeat (39) begin
      step();
      if (frm_err) pulses++;
    end
    check("t3_one_pulse", pulses, 1);
    check("t3_idle", busy, 0);
    rx_no_stop = 1'b0;
    step();
    send_frame(8'h01, 8'h00, 8'h05, 8'h04);
    check("t3_wr_en",   wr_en,   1);
    check("t3_wr_addr", wr_addr, 32'h01);
    check("t3_wr_data", wr_data, 32'h0005);

    // 4a: silence until timeout
    send_byte(8'hAA); send_byte(8'h02);
    wait_ticks(320, pulses);
    check("t4_no_early_err", pulses, 0);
    check("t4_tmo_err", frm_err, 1);
    check("t4_tmo_idle", busy, 0);

    // 4b: next byte lands on tick 319
    step();
    send_byte(8'hAA); send_byte(8'h02);
    wait_ticks(318, pulses);
    guard = 0;
    while (!ena && guard < 8) begin step(); guard++; end
    check("t4b_ena_found", ena, 1);
    send_byte(8'h11);
    check("t4b_no_err", frm_err, 0);
    check("t4b_busy",   busy,    1);
    check("t4b_no_early", pulses, 0);
    send_byte(8'h22); send_byte(8'h31);
    check("t4b_wr_en",   wr_en,   1);
    check("t4b_wr_addr", wr_addr, 32'h02);
    check("t4b_wr_data", wr_data, 32'h1122);

    // 5: garbage in IDLE, header value used as payload
    send_byte(8'h55); send_byte(8'h00); send_byte(8'hFF);
    check("t5_garbage_idle", busy, 0);
    check("t5_garbage_err",  frm_err, 0);
    send_frame(8'h03, 8'hAA, 8'hAA, 8'h03);
    check("t5_wr_en",   wr_en,   1);
    check("t5_wr_addr", wr_addr, 32'h03);
    check("t5_wr_data", wr_data, 32'hAAAA);

    // 5b: reset mid-frame
    send_byte(8'hAA); send_byte(8'h04);
    rst = 1'b1;
    step();
    check("t5_rst_busy",    busy,    0);
    check("t5_rst_wr_addr", wr_addr, 0);
    check("t5_rst_wr_data", wr_data, 0);
    check("t5_rst_wr_en",   wr_en,   0);
    check("t5_rst_frm_err", frm_err, 0);
`ifdef UART_CMD_ERRCNT_EN
    check("t5_rst_err_cnt", err_cnt, 0);
`endif
    rst = 1'b0;
    step();
    send_frame(8'h07, 8'h12, 8'h34, 8'h21);
    check("t5_post_wr_en",   wr_en,   1);
    check("t5_post_wr_addr", wr_addr, 32'h07);
    check("t5_post_wr_data", wr_data, 32'h1234);

`ifdef UART_CMD_ERRCNT_EN
    // 6: counter saturation
    send_frame(8'h12, 8'h34, 8'h56, 8'h71);
    check("t6_err_cnt_one", err_cnt, 1);
    repeat (299) send_frame(8'h12, 8'h34, 8'h56, 8'h71);
    step();
    check("t6_err_cnt_sat", err_cnt, 32'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
